// File: rtl/t2mi_ts_packer.sv
// Re-segments a byte-wide T2-MI packet stream into 188-byte MPEG-TS packets on a
// configurable PID, with PUSI/pointer_field, continuity counter and optional null stuffing.
module t2mi_ts_packer #(
  parameter int FIFO_AW = 11,
  parameter int SOP_AW  = 7
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA,
  input  logic        ENA,
  input  logic [7:0]  POINTER,
  input  logic [12:0] PID,
  input  logic        NULL_INS,
  input  logic        OUT_RD,
  output logic [7:0]  TS_DATA,
  output logic        TS_ENA,
  output logic        TS_SOP,
  output logic        TS_NULL,
  output logic        OVERFLOW
);

  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int SQ_DEPTH = 1 << SOP_AW;
  localparam logic [FIFO_AW:0]   OCC_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [SOP_AW:0]    SQ_FULL  = {1'b1, {SOP_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   OCC_MIN  = (FIFO_AW+1)'(184);
  localparam logic [FIFO_AW-1:0] D_PTR_MAX = FIFO_AW'(182);
  localparam logic [FIFO_AW-1:0] D_AF      = FIFO_AW'(183);
  localparam logic [7:0]         LAST_IDX  = 8'd187;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PTR, S_AF, S_PAYLOAD, S_NULL_PL} state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0]   r_occ;
  logic [FIFO_AW-1:0] r_sq_mem [SQ_DEPTH];
  logic [SOP_AW-1:0]  r_sq_wptr, r_sq_rptr;
  logic [SOP_AW:0]    r_sq_cnt;
  logic               r_sof;
  state_t             r_state, w_state_nxt;
  logic [7:0]         r_bidx;
  logic               r_pusi, r_af, r_null;
  logic [7:0]         r_ptr;
  logic [12:0]        r_pid;
  logic [3:0]         r_cc;
  logic [7:0]         r_ts_data;
  logic               r_ts_ena, r_ts_sop, r_ts_null, r_ovf;

  logic               w_wr, w_rd, w_push, w_pop, w_ovf, w_sq_empty;
  logic               w_start_data, w_emit, w_sop, w_nul;
  logic [7:0]         w_byte, w_hdr3;
  logic [FIFO_AW-1:0] w_head, w_d;

  assign w_sq_empty   = (r_sq_cnt == '0);
  assign w_head       = r_sq_mem[r_sq_rptr];
  assign w_d          = w_head - r_rptr;
  assign w_start_data = (r_occ >= OCC_MIN);
  // A full FIFO still accepts a byte when the read side frees a slot in the same cycle.
  assign w_wr   = ENA && ((r_occ != OCC_FULL) || w_rd);
  assign w_push = w_wr && r_sof && ((r_sq_cnt != SQ_FULL) || w_pop);
  assign w_ovf  = ENA && (!w_wr || (r_sof && !w_push));
  // Any start address streamed out as payload retires its queue entry.
  assign w_pop  = w_rd && !w_sq_empty && (w_head == r_rptr);
  assign w_hdr3 = {2'b00, (r_af ? 2'b11 : 2'b01), r_cc};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_sop       = 1'b0;
    w_nul       = 1'b0;
    w_rd        = 1'b0;
    w_byte      = 8'h00;
    if (OUT_RD) begin
      case (r_state)
        S_IDLE: begin
          if (w_start_data || NULL_INS) begin
            w_emit      = 1'b1;
            w_sop       = 1'b1;
            w_nul       = !w_start_data;
            w_byte      = 8'h47;
            w_state_nxt = S_HDR;
          end
        end
        S_HDR: begin
          w_emit = 1'b1;
          w_nul  = r_null;
          case (r_bidx)
            8'd1:    w_byte = r_null ? 8'h1F : {1'b0, r_pusi, 1'b0, r_pid[12:8]};
            8'd2:    w_byte = r_null ? 8'hFF : r_pid[7:0];
            default: w_byte = r_null ? 8'h10 : w_hdr3;
          endcase
          if (r_bidx == 8'd3)
            w_state_nxt = r_null ? S_NULL_PL : (r_pusi ? S_PTR : (r_af ? S_AF : S_PAYLOAD));
        end
        S_PTR: begin
          w_emit      = 1'b1;
          w_byte      = r_ptr;
          w_state_nxt = S_PAYLOAD;
        end
        S_AF: begin
          w_emit      = 1'b1;
          w_state_nxt = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          w_emit = 1'b1;
          w_rd   = 1'b1;
          w_byte = r_mem[r_rptr];
          if (r_bidx == LAST_IDX) w_state_nxt = S_IDLE;
        end
        S_NULL_PL: begin
          w_emit = 1'b1;
          w_nul  = 1'b1;
          w_byte = 8'hFF;
          if (r_bidx == LAST_IDX) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wptr <= '0; r_rptr <= '0; r_occ <= '0;
      r_sq_wptr <= '0; r_sq_rptr <= '0; r_sq_cnt <= '0;
      r_sof <= 1'b1; r_ovf <= 1'b0;
      r_bidx <= '0; r_pusi <= 1'b0; r_af <= 1'b0; r_null <= 1'b0; r_cc <= '0;
      r_ts_data <= '0; r_ts_ena <= 1'b0; r_ts_sop <= 1'b0; r_ts_null <= 1'b0;
    end else begin
      if (ENA)    r_sof <= (POINTER == 8'd1);
      if (w_ovf)  r_ovf <= 1'b1;
      if (w_wr)   r_wptr <= r_wptr + 1'b1;
      if (w_rd)   r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      if (w_push) r_sq_wptr <= r_sq_wptr + 1'b1;
      if (w_pop)  r_sq_rptr <= r_sq_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_sq_cnt <= r_sq_cnt + 1'b1;
        2'b01:   r_sq_cnt <= r_sq_cnt - 1'b1;
        default: r_sq_cnt <= r_sq_cnt;
      endcase
      if (w_emit) r_bidx <= (r_state == S_IDLE) ? 8'd1 : r_bidx + 8'd1;
      if (w_emit && (r_state == S_IDLE)) begin
        r_null <= !w_start_data;
        r_pusi <= w_start_data && !w_sq_empty && (w_d <= D_PTR_MAX);
        r_af   <= w_start_data && !w_sq_empty && (w_d == D_AF);
      end
      if (w_rd && (r_bidx == LAST_IDX)) r_cc <= r_cc + 1'b1;
      r_ts_ena  <= w_emit;
      r_ts_sop  <= w_sop;
      r_ts_null <= w_emit && w_nul;
      r_ts_data <= w_emit ? w_byte : 8'h00;
    end
  end

  // Storage and per-packet header fields carry no reset.
  always_ff @(posedge CLK) begin
    if (w_wr)   r_mem[r_wptr] <= DATA;
    if (w_push) r_sq_mem[r_sq_wptr] <= r_wptr;
    if (w_emit && (r_state == S_IDLE)) begin
      r_ptr <= w_d[7:0];
      r_pid <= PID;
    end
  end

  assign TS_DATA  = r_ts_data;
  assign TS_ENA   = r_ts_ena;
  assign TS_SOP   = r_ts_sop;
  assign TS_NULL  = r_ts_null;
  assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_t2mi_ts_packer.sv
// Bench for t2mi_ts_packer: directed vector table, corner sequences and a randomized
// run, all checked against a queue-based model of the TS re-segmentation rules.
module tb_t2mi_ts_packer;
  localparam int PKT = 188;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  DATA = '0;
  logic        ENA = 1'b0;
  logic [7:0]  POINTER = '0;
  logic [12:0] PID = 13'h0123;
  logic        NULL_INS = 1'b0;
  logic        OUT_RD = 1'b0;
  logic [7:0]  TS_DATA;
  logic        TS_ENA, TS_SOP, TS_NULL, OVERFLOW;

  always #5 CLK = ~CLK;

  t2mi_ts_packer #(.FIFO_AW(11), .SOP_AW(7)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ENA(ENA), .POINTER(POINTER), .PID(PID),
    .NULL_INS(NULL_INS), .OUT_RD(OUT_RD), .TS_DATA(TS_DATA), .TS_ENA(TS_ENA),
    .TS_SOP(TS_SOP), .TS_NULL(TS_NULL), .OVERFLOW(OVERFLOW)
  );

  int nchk = 0;
  int nerr = 0;

  // Reference model: bytes written and whether each begins a T2-MI packet.
  logic [7:0] mq_d[$];
  bit         mq_s[$];
  bit         m_next_start = 1'b1;
  int         m_cc = 0;
  int         m_ndata = 0;
  int         m_nnull = 0;
  bit         mon_en = 1'b1;
  logic [7:0] dseq = 8'h00;

  typedef struct { bit is_null; logic [7:0] b1; logic [7:0] b3; logic [7:0] b4; } log_t;
  log_t plog[$];

  logic [7:0] cap [PKT];
  int         col = 0;
  bit         cap_null, cap_nmix;
  logic       prev_rd = 1'b0;

  typedef struct {
    int len_a;
    int len_b;
    int npk;
    logic [2:0][23:0] h;
    bit null_after;
  } vec_t;
  vec_t vecs[3];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_packet();
    logic [7:0] exp [PKT];
    log_t       e;
    int         d, k, bad;
    bit         pusi, af;
    e.is_null = cap_null; e.b1 = cap[1]; e.b3 = cap[3]; e.b4 = cap[4];
    plog.push_back(e);
    if (!mon_en) return;
    if (cap_null) begin
      m_nnull++;
      exp[0] = 8'h47; exp[1] = 8'h1F; exp[2] = 8'hFF; exp[3] = 8'h10;
      for (int i = 4; i < PKT; i++) exp[i] = 8'hFF;
    end else begin
      m_ndata++;
      if (mq_d.size() < 184) begin
        chk("model_bytes_available", mq_d.size(), 184);
        return;
      end
      d = -1;
      for (int i = 0; i < 184; i++) if (d < 0 && mq_s[i]) d = i;
      pusi = (d >= 0) && (d <= 182);
      af   = (d == 183);
      exp[0] = 8'h47;
      exp[1] = {1'b0, pusi, 1'b0, PID[12:8]};
      exp[2] = PID[7:0];
      exp[3] = {2'b00, (af ? 2'b11 : 2'b01), 4'(m_cc)};
      k = 4;
      if (pusi || af) begin exp[4] = pusi ? 8'(d) : 8'h00; k = 5; end
      while (k < PKT) begin
        exp[k] = mq_d.pop_front();
        void'(mq_s.pop_front());
        k++;
      end
      m_cc = (m_cc + 1) % 16;
    end
    bad = -1;
    for (int i = PKT - 1; i >= 0; i--) if (cap[i] !== exp[i]) bad = i;
    nchk++;
    if (bad >= 0 || cap_nmix) begin
      nerr++;
      if (bad < 0) bad = 0;
      $display("FAIL packet %0d byte %0d: got %02h expected %02h (null flag mixed=%0d)",
               plog.size() - 1, bad, cap[bad], exp[bad], cap_nmix);
    end
  endtask

  always @(posedge CLK) prev_rd <= OUT_RD;

  always @(negedge CLK) begin
    if (!RST) begin
      col = 0;
    end else if (TS_ENA) begin
      chk("ena_follows_rd", {31'b0, prev_rd}, 32'd1);
      if (TS_SOP) begin
        chk("sop_position", col, 0);
        col = 0; cap_null = TS_NULL; cap_nmix = 1'b0;
      end else if (col == 0) begin
        chk("sop_missing", {31'b0, TS_SOP}, 32'd1);
      end
      if (TS_NULL !== cap_null) cap_nmix = 1'b1;
      cap[col] = TS_DATA;
      col++;
      if (col == PKT) begin
        check_packet();
        col = 0;
      end
    end
  end

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b0; ENA = 1'b0; OUT_RD = 1'b0; NULL_INS = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    mq_d.delete(); mq_s.delete();
    m_next_start = 1'b1; m_cc = 0; m_ndata = 0; m_nnull = 0;
    plog.delete();
    RST = 1'b1;
  endtask

  task automatic idle_cycle();
    @(posedge CLK); #1;
    ENA = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle per byte, 2 random idle cycles
  task automatic send(input int len, input int gap);
    for (int i = 0; i < len; i++) begin
      if (gap == 1) idle_cycle();
      if (gap == 2) while ($urandom_range(2) == 0) idle_cycle();
      @(posedge CLK); #1;
      ENA = 1'b1;
      DATA = dseq;
      POINTER = (len - i > 255) ? 8'd255 : 8'(len - i);
      mq_d.push_back(dseq);
      mq_s.push_back(m_next_start);
      m_next_start = (len - i == 1);
      dseq = dseq + 8'd37;
    end
    @(posedge CLK); #1;
    ENA = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int c = 0;
    while (plog.size() < n && c < budget) begin @(posedge CLK); c++; end
    if (plog.size() < n) chk("wait_packets_timeout", plog.size(), n);
  endtask

  task automatic set_vec(input int idx, input int a, input int b, input int n,
                         input logic [23:0] h0, input logic [23:0] h1,
                         input logic [23:0] h2, input bit nul);
    vecs[idx].len_a = a; vecs[idx].len_b = b; vecs[idx].npk = n;
    vecs[idx].h[0] = h0; vecs[idx].h[1] = h1; vecs[idx].h[2] = h2;
    vecs[idx].null_after = nul;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  cnt, budget;
    bit  done;
    // {byte1, byte3, byte4} of each expected TS packet, PID 0x0123
    set_vec(0, 200, 0,   1, 24'h41_10_00, 24'h0,        24'h0,        1'b1);
    set_vec(1, 183, 300, 2, 24'h41_10_00, 24'h41_11_00, 24'h0,        1'b0);
    set_vec(2, 366, 200, 3, 24'h41_10_00, 24'h01_31_00, 24'h41_12_00, 1'b0);

    do_reset();
    @(negedge CLK);
    chk("reset_outputs", {TS_DATA, TS_ENA, TS_SOP, TS_NULL, OVERFLOW}, 0);

    for (int v = 0; v < 3; v++) begin
      do_reset();
      PID = 13'h0123; OUT_RD = 1'b1;
      send(vecs[v].len_a, 0);
      if (vecs[v].len_b > 0) send(vecs[v].len_b, 0);
      wait_log(vecs[v].npk, 3000);
      repeat (400) @(posedge CLK);
      chk($sformatf("v%0d_pkt_count", v), plog.size(), vecs[v].npk);
      for (int k = 0; k < vecs[v].npk; k++) begin
        if (k < plog.size()) begin
          chk($sformatf("v%0d_hdr%0d", v, k), {plog[k].b1, plog[k].b3, plog[k].b4}, vecs[v].h[k]);
          chk($sformatf("v%0d_notnull%0d", v, k), {31'b0, plog[k].is_null}, 0);
        end
      end
      if (vecs[v].null_after) begin
        #1 NULL_INS = 1'b1;
        wait_log(vecs[v].npk + 1, 1000);
        if (plog.size() > vecs[v].npk) begin
          chk("null_hdr", {plog[vecs[v].npk].b1, plog[vecs[v].npk].b3, plog[vecs[v].npk].b4}, 24'h1F_10_FF);
          chk("null_flag", {31'b0, plog[vecs[v].npk].is_null}, 1);
        end
      end
    end

    // Minimum latency: 184th byte written at edge E0, decision at E1, SOP visible after E1.
    do_reset();
    OUT_RD = 1'b1;
    send(184, 0);
    @(negedge CLK);
    chk("latency_sop_early", {31'b0, TS_SOP}, 0);
    @(negedge CLK);
    chk("latency_sop", {31'b0, TS_SOP}, 1);
    chk("latency_sync", TS_DATA, 8'h47);
    wait_log(1, 1000);

    // OUT_RD toggling every cycle
    do_reset();
    fork
      send(400, 0);
      begin
        repeat (1200) begin @(posedge CLK); #1; OUT_RD = ~OUT_RD; end
      end
    join
    chk("toggle_pkt_count", plog.size(), 2);
    if (plog.size() >= 2) begin
      chk("toggle_hdr0", {plog[0].b1, plog[0].b3}, 16'h41_10);
      chk("toggle_hdr1", {plog[1].b1, plog[1].b3}, 16'h01_11);
    end

    // Continuity counter over 17 data packets with nulls interleaved
    do_reset();
    PID = 13'h1ABC; OUT_RD = 1'b1; NULL_INS = 1'b1;
    send(3200, 1);
    budget = 0;
    while (m_ndata < 17 && budget < 3000) begin @(posedge CLK); budget++; end
    chk("cc_data_pkts", (m_ndata >= 17), 1);
    cnt = 0;
    for (int k = 0; k < plog.size(); k++) begin
      if (!plog[k].is_null && cnt < 17) begin
        chk($sformatf("cc_seq%0d", cnt), plog[k].b3[3:0], cnt % 16);
        cnt++;
      end
    end
    chk("cc_nulls_seen", (m_nnull > 0), 1);

    // Randomized stream against the model
    do_reset();
    PID = 13'($urandom);
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 30; p++)
          send(($urandom_range(3) == 0) ? $urandom_range(1, 40) : $urandom_range(41, 500), 2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK); #1;
          OUT_RD = ($urandom_range(3) != 0);
          if ($urandom_range(15) == 0) NULL_INS = ~NULL_INS;
        end
      end
    join
    OUT_RD = 1'b1; NULL_INS = 1'b0;
    budget = 0;
    while (mq_d.size() >= 184 && budget < 20000) begin @(posedge CLK); budget++; end
    repeat (400) @(posedge CLK);
    chk("rand_drained", (mq_d.size() < 184), 1);
    chk("rand_data_seen", (m_ndata > 10), 1);
    chk("rand_no_overflow", {31'b0, OVERFLOW}, 0);

    // Overflow on the 2049th byte, then reset in the middle of a packet
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < 2049; i++) begin
      @(posedge CLK); #1;
      if (i == 2048) chk("ovf_before_2049", {31'b0, OVERFLOW}, 0);
      ENA = 1'b1; DATA = 8'(i); POINTER = 8'd255;
    end
    @(posedge CLK); #1;
    ENA = 1'b0;
    chk("ovf_set", {31'b0, OVERFLOW}, 1);
    repeat (10) @(posedge CLK);
    #1;
    chk("ovf_sticky", {31'b0, OVERFLOW}, 1);
    OUT_RD = 1'b1;
    repeat (40) @(posedge CLK);
    #1;
    chk("ovf_streaming", {31'b0, TS_ENA}, 1);
    RST = 1'b0;
    #1;
    chk("midpkt_reset_outputs", {TS_DATA, TS_ENA, TS_SOP, TS_NULL, OVERFLOW}, 0);
    repeat (2) @(posedge CLK);
    #1;
    mq_d.delete(); mq_s.delete();
    m_next_start = 1'b1; m_cc = 0; m_ndata = 0; m_nnull = 0;
    plog.delete();
    mon_en = 1'b1; PID = 13'h0123;
    RST = 1'b1;
    send(200, 0);
    wait_log(1, 1000);
    if (plog.size() >= 1)
      chk("after_reset_hdr", {plog[0].b1, plog[0].b3, plog[0].b4}, 24'h41_10_00);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
